// File: rtl/aurora_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : aurora_pkg                                                      |
// | Brief    : Block constants, sync headers and lane state for the Aurora     |
// |            multi-lane 64b/66b transmit framer.                             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package aurora_pkg;

  // 66-bit sync headers
  localparam logic [1:0] c_sync_data = 2'b01;
  localparam logic [1:0] c_sync_ctrl = 2'b10;

  // Block type fields of control blocks
  localparam logic [7:0] c_btf_idle  = 8'h78;
  localparam logic [7:0] c_btf_sep   = 8'h1E;
  localparam logic [7:0] c_btf_userk = 8'hD2;

  // Fixed control blocks
  localparam logic [65:0] c_blk_idle = {c_sync_ctrl, c_btf_idle, 56'h0};
  localparam logic [65:0] c_blk_cc   = {c_sync_ctrl, c_btf_idle, 8'h80, 48'h0};
  localparam logic [65:0] c_blk_sep  = {c_sync_ctrl, c_btf_sep, 56'h0};

  typedef enum logic [0:0] {
    INIT_LANE  = 1'b0,
    LANE_READY = 1'b1
  } lane_state_e;

  function automatic logic [65:0] f_blk_data(input logic [63:0] word);
    return {c_sync_data, word};
  endfunction

  function automatic logic [65:0] f_blk_userk(input logic [15:0] mon);
    return {c_sync_ctrl, c_btf_userk, 40'h0, mon};
  endfunction

endpackage

`default_nettype wire

// File: rtl/aurora_cc_scheduler.sv
// +----------------------------------------------------------------------------+
// | Module   : aurora_cc_scheduler                                             |
// | Brief    : Ack-driven clock-compensation scheduler. Waits CC_WAIT acks,    |
// |            then flags CC for CC_SEND acks, then starts over.               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module aurora_cc_scheduler #(
  parameter int CC_WAIT = 128,
  parameter int CC_SEND = 4
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic i_enable,
  input  logic i_ack,
  output logic o_cc_active
);

  localparam int c_cnt_max = (CC_WAIT > CC_SEND) ? CC_WAIT : CC_SEND;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
  localparam logic [c_cnt_w-1:0] c_wait_last = c_cnt_w'(CC_WAIT - 1);
  localparam logic [c_cnt_w-1:0] c_send_last = c_cnt_w'(CC_SEND - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_burst;

  // Count acks while lanes are up; toggle between wait and burst phases
  always_ff @(posedge Clk) begin
    if (!Rst_n || !i_enable) begin
      r_cnt   <= '0;
      r_burst <= 1'b0;
    end else if (i_ack) begin
      if (r_burst ? (r_cnt == c_send_last) : (r_cnt == c_wait_last)) begin
        r_cnt   <= '0;
        r_burst <= ~r_burst;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_cc_active = r_burst;

endmodule

`default_nettype wire

// File: rtl/aurora_multilane_tx_framer.sv
// +----------------------------------------------------------------------------+
// | Module   : aurora_multilane_tx_framer                                      |
// | Brief    : Stripes a 64-bit user stream round-robin over NUM_LANES Aurora  |
// |            lanes, inserting CC, monitor User-K and frame separators.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module aurora_multilane_tx_framer #(
  parameter int NUM_LANES = 4,
  parameter int INIT_WAIT = 1280,
  parameter int CC_WAIT   = 128,
  parameter int CC_SEND   = 4
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic [63:0]               DataIn,
  input  logic                      DataEmpty,
  input  logic                      DataLast,
  output logic                      DataRead,
  input  logic [15:0]               Monitor,
  input  logic                      MonitorEmpty,
  output logic                      MonitorRead,
  input  logic [NUM_LANES-1:0]      SerializerLock,
  input  logic                      AuroraAck,
  output logic [66*NUM_LANES-1:0]   AuroraBlock,
  output logic                      LaneReady
);

  import aurora_pkg::*;

  localparam int c_init_w = $clog2(INIT_WAIT + 1);
  localparam int c_fp_w   = $clog2(NUM_LANES + 1);
  localparam logic [c_init_w-1:0] c_init_last = c_init_w'(INIT_WAIT - 1);
  localparam logic [c_fp_w-1:0]   c_fp_full   = c_fp_w'(NUM_LANES);

  lane_state_e                r_state, w_state_nxt;
  logic [c_init_w-1:0]        r_init_cnt, w_init_cnt_nxt;
  logic [65:0]                r_slot [NUM_LANES];
  logic [c_fp_w-1:0]          r_fp;
  logic                       r_sep_pending;
  logic                       r_userk_last;
  logic [66*NUM_LANES-1:0]    r_block;
  logic [66*NUM_LANES-1:0]    w_block_nxt;
  logic                       w_load_data;

  logic        w_ready, w_lock_ok, w_cc_active, w_fill_ok;
  logic        w_data_rd, w_sep_ins, w_fill, w_mon_rd;
  logic [65:0] w_fill_blk;

  assign w_ready    = (r_state == LANE_READY);
  assign w_lock_ok  = &SerializerLock;
  // Staging is only touched between acks, outside CC bursts, with room left
  assign w_fill_ok  = w_ready & (r_fp < c_fp_full) & ~AuroraAck & ~w_cc_active;
  assign w_data_rd  = w_fill_ok & ~DataEmpty & ~r_sep_pending;
  assign w_sep_ins  = w_fill_ok & r_sep_pending;
  assign w_fill     = w_data_rd | w_sep_ins;
  assign w_fill_blk = w_data_rd ? f_blk_data(DataIn) : c_blk_sep;
  assign w_mon_rd   = w_ready & AuroraAck & ~w_cc_active & ~MonitorEmpty & ~r_userk_last;

  aurora_cc_scheduler #(
    .CC_WAIT (CC_WAIT),
    .CC_SEND (CC_SEND)
  ) u_cc_scheduler (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .i_enable    (w_ready),
    .i_ack       (AuroraAck),
    .o_cc_active (w_cc_active)
  );

  // Lane state and init-ack counter registers
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state    <= INIT_LANE;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
    end
  end

  // Lane bring-up: count locked acks, fall back on any lock loss
  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    case (r_state)
      INIT_LANE: begin
        if (!w_lock_ok) begin
          w_init_cnt_nxt = '0;
        end else if (AuroraAck) begin
          if (r_init_cnt == c_init_last) begin
            w_state_nxt    = LANE_READY;
            w_init_cnt_nxt = '0;
          end else begin
            w_init_cnt_nxt = r_init_cnt + 1'b1;
          end
        end
      end
      LANE_READY: begin
        if (!w_lock_ok) begin
          w_state_nxt    = INIT_LANE;
          w_init_cnt_nxt = '0;
        end
      end
    endcase
  end

  // Staging slot payload; validity is tracked by the fill pointer alone
  always_ff @(posedge Clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (w_fill && (r_fp == c_fp_w'(i))) begin
        r_slot[i] <= w_fill_blk;
      end
    end
  end

  // Fill pointer and pending separator; only a data ack drains the staging
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_fp          <= '0;
      r_sep_pending <= 1'b0;
    end else if (AuroraAck) begin
      if (w_load_data) begin
        r_fp <= '0;
      end
    end else if (w_fill) begin
      r_fp          <= r_fp + 1'b1;
      r_sep_pending <= w_data_rd & DataLast;
    end
  end

  // Choose the next block set: IDLE, CC, User-K, then staged data
  always_comb begin
    w_block_nxt = {NUM_LANES{c_blk_idle}};
    w_load_data = 1'b0;
    if (w_ready) begin
      if (w_cc_active) begin
        w_block_nxt = {NUM_LANES{c_blk_cc}};
      end else if (w_mon_rd) begin
        w_block_nxt[65:0] = f_blk_userk(Monitor);
      end else begin
        w_load_data = 1'b1;
        for (int i = 0; i < NUM_LANES; i++) begin
          if (c_fp_w'(i) < r_fp) begin
            w_block_nxt[66*i +: 66] = r_slot[i];
          end
        end
      end
    end
  end

  // Output blocks advance on each ack; User-K is never sent twice in a row
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_block      <= {NUM_LANES{c_blk_idle}};
      r_userk_last <= 1'b0;
    end else if (AuroraAck) begin
      r_block      <= w_block_nxt;
      r_userk_last <= w_mon_rd;
    end
  end

  assign DataRead    = w_data_rd;
  assign MonitorRead = w_mon_rd;
  assign AuroraBlock = r_block;
  assign LaneReady   = w_ready;

endmodule

`default_nettype wire
